// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - two-port memory arbiter bus bundle
//
// Purpose: groups the port 0 (CPU) and port 1 (loader) request/response
// signals, the memory-side access signals and the busy flag.
// Modports:
//   slave  - arbiter side: takes requests and mem_rdata_in; drives acks,
//            read data, memory strobes and busy_out.
//   master - environment side: ports plus memory model, the mirror image.
interface mem_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          req0_in;
  logic          req1_in;
  logic          wen0_in;
  logic          wen1_in;
  logic [AW-1:0] addr0_in;
  logic [AW-1:0] addr1_in;
  logic [DW-1:0] wdata0_in;
  logic [DW-1:0] wdata1_in;
  logic          ack0_out;
  logic          ack1_out;
  logic [DW-1:0] rdata0_out;
  logic [DW-1:0] rdata1_out;
  logic          mem_en_out;
  logic          mem_wen_out;
  logic [AW-1:0] mem_addr_out;
  logic [DW-1:0] mem_wdata_out;
  logic [DW-1:0] mem_rdata_in;
  logic          busy_out;

  modport slave (
    input  req0_in, req1_in, wen0_in, wen1_in, addr0_in, addr1_in,
           wdata0_in, wdata1_in, mem_rdata_in,
    output ack0_out, ack1_out, rdata0_out, rdata1_out, mem_en_out,
           mem_wen_out, mem_addr_out, mem_wdata_out, busy_out
  );

  modport master (
    output req0_in, req1_in, wen0_in, wen1_in, addr0_in, addr1_in,
           wdata0_in, wdata1_in, mem_rdata_in,
    input  ack0_out, ack1_out, rdata0_out, rdata1_out, mem_en_out,
           mem_wen_out, mem_addr_out, mem_wdata_out, busy_out
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin two-port single-memory arbiter
//
// Purpose: serialises accesses from port 0 (CPU) and port 1 (loader) onto
// one synchronous memory. Each access takes IDLE/RSP -> ACC -> RSP; when the
// other port is waiting, RSP goes straight to ACC, giving one access per two
// cycles under contention. Ties are broken by a round-robin pointer.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - mem_arbiter_if.slave: req/wen/addr/wdata in and ack/rdata out for
//          both ports, mem_en/mem_wen/mem_addr/mem_wdata out, mem_rdata in,
//          busy_out
module mem_arbiter #(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACC, RSP} state_t;

  state_t        state;
  state_t        next_state;
  logic          gnt;
  logic          prio;
  logic          wen_r;
  logic [AW-1:0] addr_r;
  logic [DW-1:0] wdata_r;
  logic          load;
  logic          sel;
  logic          in_rsp;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      gnt     <= 1'b0;
      prio    <= 1'b0;
      wen_r   <= 1'b0;
      addr_r  <= '0;
      wdata_r <= '0;
    end else begin
      state <= next_state;
      if (load) begin
        gnt     <= sel;
        prio    <= ~sel;
        wen_r   <= sel ? bus.wen1_in   : bus.wen0_in;
        addr_r  <= sel ? bus.addr1_in  : bus.addr0_in;
        wdata_r <= sel ? bus.wdata1_in : bus.wdata0_in;
      end
    end
  end

  always_comb begin
    next_state = state;
    load       = 1'b0;
    sel        = gnt;
    case (state)
      IDLE: begin
        if (bus.req0_in || bus.req1_in) begin
          load       = 1'b1;
          // single requester wins outright; a tie goes to prio
          sel        = (bus.req0_in && bus.req1_in) ? prio : bus.req1_in;
          next_state = ACC;
        end
      end
      ACC: next_state = RSP;
      RSP: begin
        next_state = IDLE;
        // the port being acked is ignored so it cannot win twice in a row
        if (gnt ? bus.req0_in : bus.req1_in) begin
          load       = 1'b1;
          sel        = ~gnt;
          next_state = ACC;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Strobes are gated by rst so outputs are quiet from the first reset cycle,
  // before the state register has been cleared.
  assign in_rsp            = !rst && (state == RSP);
  assign bus.mem_en_out    = !rst && (state == ACC);
  assign bus.mem_wen_out   = bus.mem_en_out && wen_r;
  assign bus.mem_addr_out  = addr_r;
  assign bus.mem_wdata_out = wdata_r;
  assign bus.busy_out      = !rst && (state != IDLE);
  assign bus.ack0_out      = in_rsp && !gnt;
  assign bus.ack1_out      = in_rsp && gnt;
  assign bus.rdata0_out    = (bus.ack0_out && !wen_r) ? bus.mem_rdata_in : '0;
  assign bus.rdata1_out    = (bus.ack1_out && !wen_r) ? bus.mem_rdata_in : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(16), .DW(16)) bus ();

  mem_arbiter #(.AW(16), .DW(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic        rst, req0, req1, wen0, wen1;
    logic [15:0] a0, a1, d0, d1, mrd;
    logic        ack0, ack1;
    logic [15:0] rd0, rd1;
    logic        men, mwen;
    logic [15:0] maddr, mwdata;
    logic        busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic r, q0, q1, w0, w1,
    input logic [15:0] a0, a1, d0, d1, mrd,
    input logic k0, k1, input logic [15:0] rd0, rd1,
    input logic men, mwen, input logic [15:0] maddr, mwdata,
    input logic busy);
    vec_t v;
    v.rst = r; v.req0 = q0; v.req1 = q1; v.wen0 = w0; v.wen1 = w1;
    v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1; v.mrd = mrd;
    v.ack0 = k0; v.ack1 = k1; v.rd0 = rd0; v.rd1 = rd1;
    v.men = men; v.mwen = mwen; v.maddr = maddr; v.mwdata = mwdata;
    v.busy = busy;
    return v;
  endfunction

  task automatic chk(input string name, input int tag, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %h want %h", name, tag, act, exp);
    end
  endtask

  task automatic drive(input logic q0, q1, w0, w1, input logic [15:0] a0, a1, d0, d1, mrd);
    bus.req0_in = q0; bus.req1_in = q1; bus.wen0_in = w0; bus.wen1_in = w1;
    bus.addr0_in = a0; bus.addr1_in = a1; bus.wdata0_in = d0; bus.wdata1_in = d1;
    bus.mem_rdata_in = mrd;
  endtask

  initial begin
    int a0_cnt;
    int a1_cnt;
    logic last;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Each row: apply inputs at negedge, clock once, compare at next negedge.
    //            rst q0 q1 w0 w1 a0       a1       d0       d1       mrd       k0 k1 rd0      rd1      en wen maddr    mwdata   busy
    vecs.push_back(mk(1, 1, 1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0));
    // single read, port 0
    vecs.push_back(mk(0, 1, 0, 0, 0, 16'h0010, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0010, 16'h0000, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 16'h0010, 16'h0000, 16'h0000, 16'h0000, 16'hBEEF, 1, 0, 16'hBEEF, 16'h0000, 0, 0, 16'h0010, 16'h0000, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0010, 16'h0000, 0));
    // write, port 1
    vecs.push_back(mk(0, 0, 1, 0, 1, 16'h0000, 16'h00FF, 16'h0000, 16'h1234, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 1, 16'h00FF, 16'h1234, 1));
    vecs.push_back(mk(0, 0, 1, 0, 1, 16'h0000, 16'h00FF, 16'h0000, 16'h1234, 16'hAAAA, 0, 1, 16'h0000, 16'h0000, 0, 0, 16'h00FF, 16'h1234, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h00FF, 16'h1234, 0));
    // tie: port 0 first (prio 0), port 1 straight from RSP
    vecs.push_back(mk(0, 1, 1, 0, 0, 16'h0100, 16'h0200, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0100, 16'h0000, 1));
    vecs.push_back(mk(0, 1, 1, 0, 0, 16'h0100, 16'h0200, 16'h0000, 16'h0000, 16'h1111, 1, 0, 16'h1111, 16'h0000, 0, 0, 16'h0100, 16'h0000, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 16'h0000, 16'h0200, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0200, 16'h0000, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 16'h0000, 16'h0200, 16'h0000, 16'h0000, 16'h2222, 0, 1, 16'h0000, 16'h2222, 0, 0, 16'h0200, 16'h0000, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0200, 16'h0000, 0));
    // req dropped mid-access still completes
    vecs.push_back(mk(0, 1, 0, 1, 0, 16'h0033, 16'h0000, 16'h5555, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 1, 16'h0033, 16'h5555, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h9999, 1, 0, 16'h0000, 16'h0000, 0, 0, 16'h0033, 16'h5555, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0033, 16'h5555, 0));

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst;
      drive(vecs[i].req0, vecs[i].req1, vecs[i].wen0, vecs[i].wen1,
            vecs[i].a0, vecs[i].a1, vecs[i].d0, vecs[i].d1, vecs[i].mrd);
      @(posedge clk);
      @(negedge clk);
      chk("ack0",   i, 16'(bus.ack0_out),    16'(vecs[i].ack0));
      chk("ack1",   i, 16'(bus.ack1_out),    16'(vecs[i].ack1));
      chk("rdata0", i, bus.rdata0_out,       vecs[i].rd0);
      chk("rdata1", i, bus.rdata1_out,       vecs[i].rd1);
      chk("mem_en", i, 16'(bus.mem_en_out),  16'(vecs[i].men));
      chk("mem_wen", i, 16'(bus.mem_wen_out), 16'(vecs[i].mwen));
      chk("mem_addr", i, bus.mem_addr_out,   vecs[i].maddr);
      chk("mem_wdata", i, bus.mem_wdata_out, vecs[i].mwdata);
      chk("busy",   i, 16'(bus.busy_out),    16'(vecs[i].busy));
    end

    // Fairness: reset so prio starts at 0, then both ports hold req.
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    drive(1, 1, 0, 0, 16'h0A00, 16'h0B00, 0, 0, 16'h0F0F);
    a0_cnt = 0;
    a1_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); @(negedge clk);
      chk("fair_ack0", 100 + k, 16'(bus.ack0_out), 16'((k % 4) == 1));
      chk("fair_ack1", 100 + k, 16'(bus.ack1_out), 16'((k % 4) == 3));
      chk("fair_en",   100 + k, 16'(bus.mem_en_out), 16'((k % 2) == 0));
      chk("fair_addr", 100 + k, bus.mem_addr_out, ((k % 4) < 2) ? 16'h0A00 : 16'h0B00);
      if (bus.ack0_out) a0_cnt++;
      if (bus.ack1_out) a1_cnt++;
    end
    chk("fair_cnt0", 200, 16'(a0_cnt), 16'd5);
    chk("fair_cnt1", 201, 16'(a1_cnt), 16'd5);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    chk("fair_idle", 202, 16'(bus.busy_out), 16'd0);

    // Reset during port 0 ACC aborts it; held req is served afresh.
    drive(1, 0, 0, 0, 16'h0042, 0, 0, 0, 16'h7777);
    @(posedge clk); @(negedge clk);
    chk("abort_acc_en", 300, 16'(bus.mem_en_out), 16'd1);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("abort_ack0", 301, 16'(bus.ack0_out), 16'd0);
    chk("abort_busy", 302, 16'(bus.busy_out), 16'd0);
    chk("abort_addr", 303, bus.mem_addr_out, 16'h0000);
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("retry_en",   304, 16'(bus.mem_en_out), 16'd1);
    chk("retry_ack0", 305, 16'(bus.ack0_out), 16'd0);
    chk("retry_addr", 306, bus.mem_addr_out, 16'h0042);
    @(posedge clk); @(negedge clk);
    chk("retry_ack", 307, 16'(bus.ack0_out), 16'd1);
    chk("retry_rd",  308, bus.rdata0_out, 16'h7777);
    last = bus.ack1_out;
    chk("retry_ack1", 309, 16'(last), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Mutual exclusion of acks is watched on every sample point.
  always @(negedge clk) begin
    if (bus.ack0_out === 1'b1 && bus.ack1_out === 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ack_excl: got ack0=1 ack1=1 want at most one");
    end
  end

endmodule
